// File: rtl/soc_cfg_pkg.sv
// Shared SoC configuration constants and helpers for the SRAM responder and its
// config-register block.
package soc_cfg_pkg;

  // Default base of the config window; only bits [31:16] take part in the match.
  localparam logic [31:0] CONF_BASE_DEFAULT = 32'hBFAF_0000;

  // Register offsets within the config window (addr[15:0]).
  localparam logic [15:0] CONF_LED_OFS    = 16'hF000;
  localparam logic [15:0] CONF_NUM_OFS    = 16'hF010;
  localparam logic [15:0] CONF_TIMER_OFS  = 16'hF020;
  localparam logic [15:0] CONF_SWITCH_OFS = 16'hF030;

  // Decoded config register select.
  typedef enum logic [2:0] {
    SelNone,
    SelLed,
    SelNum,
    SelTimer,
    SelSwitch
  } conf_sel_e;

  // Replace each byte of old_word whose enable is set with the matching byte of new_word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  we);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

  // Map a window offset onto a register select; unknown offsets map to SelNone.
  function automatic conf_sel_e conf_decode(input logic [15:0] ofs);
    conf_sel_e sel;
    case (ofs)
      CONF_LED_OFS:    sel = SelLed;
      CONF_NUM_OFS:    sel = SelNum;
      CONF_TIMER_OFS:  sel = SelTimer;
      CONF_SWITCH_OFS: sel = SelSwitch;
      default:         sel = SelNone;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/conf_regs.sv
// Config-register block: LED, numeric display, free-running timer, switch
// synchronizer and the combinational config read mux.
module conf_regs
  import soc_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        wr_en,     // config write this cycle (en, window hit, we != 0)
  input  logic [3:0]  we,
  input  logic [15:0] ofs,
  input  logic [31:0] wdata,
  input  logic [7:0]  switch,
  output logic [31:0] rdata,     // pre-write register value for offset ofs
  output logic [15:0] led,
  output logic [31:0] num_data
);

  conf_sel_e   sel;
  logic [15:0] led_q, led_d;
  logic [31:0] num_q, num_d;
  logic [31:0] timer_q, timer_d;
  logic [7:0]  sw_meta_q, sw_sync_q;
  logic [31:0] led_merged;

  assign sel        = conf_decode(ofs);
  assign led_merged = byte_merge({16'h0000, led_q}, wdata, we);

  // Next-state for the writable registers; a timer write overrides the increment.
  always_comb begin
    led_d   = led_q;
    num_d   = num_q;
    timer_d = timer_q + 32'd1;
    if (wr_en) begin
      case (sel)
        SelLed:   led_d   = led_merged[15:0];
        SelNum:   num_d   = byte_merge(num_q, wdata, we);
        SelTimer: timer_d = byte_merge(timer_q, wdata, we);
        default:  ;
      endcase
    end
  end

  // Register state and the two-flop switch synchronizer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_q     <= '0;
      num_q     <= '0;
      timer_q   <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      led_q     <= led_d;
      num_q     <= num_d;
      timer_q   <= timer_d;
      sw_meta_q <= switch;
      sw_sync_q <= sw_meta_q;
    end
  end

  // Read mux over current register values, so a write cycle reads the old value.
  always_comb begin
    rdata = '0;
    case (sel)
      SelLed:    rdata = {16'h0000, led_q};
      SelNum:    rdata = num_q;
      SelTimer:  rdata = timer_q;
      SelSwitch: rdata = {24'h000000, sw_sync_q};
      default:   rdata = '0;
    endcase
  end

  assign led      = led_q;
  assign num_data = num_q;

  logic unused_ok;
  assign unused_ok = ^led_merged[31:16];

endmodule

// File: rtl/sram_responder.sv
// Memory-side responder for the core's instruction and data SRAM ports: one shared
// word-addressed RAM with one-cycle registered reads, plus the config window on the
// data port.
module sram_responder
  import soc_cfg_pkg::*;
#(
  parameter int unsigned RAM_AW    = 14,
  parameter logic [31:0] CONF_BASE = CONF_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_we,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  output logic [31:0] num_data,
  input  logic [7:0]  switch
);

  localparam int unsigned RamWords = 1 << RAM_AW;

  logic [31:0]       mem [RamWords];
  logic [RAM_AW-1:0] inst_idx, data_idx;
  logic              conf_hit;
  logic              conf_wr;
  logic [3:0]        ram_we;
  logic [31:0]       conf_rdata;
  logic [31:0]       inst_rdata_q, data_rdata_q;

  // High address bits above the RAM index simply alias into the RAM.
  assign inst_idx = inst_sram_addr[RAM_AW+1:2];
  assign data_idx = data_sram_addr[RAM_AW+1:2];
  assign conf_hit = (data_sram_addr[31:16] == CONF_BASE[31:16]);
  assign conf_wr  = data_sram_en && conf_hit && (data_sram_we != 4'b0000);
  assign ram_we   = (data_sram_en && !conf_hit) ? data_sram_we : 4'b0000;

  // Byte-enable RAM write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we[i]) begin
        mem[data_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  // Registered read data; sampling mem alongside the write gives read-first on both ports.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      if (inst_sram_en) begin
        inst_rdata_q <= mem[inst_idx];
      end
      if (data_sram_en) begin
        data_rdata_q <= conf_hit ? conf_rdata : mem[data_idx];
      end
    end
  end

  conf_regs u_conf_regs (
    .clk      (clk),
    .resetn   (resetn),
    .wr_en    (conf_wr),
    .we       (data_sram_we),
    .ofs      (data_sram_addr[15:0]),
    .wdata    (data_sram_wdata),
    .switch   (switch),
    .rdata    (conf_rdata),
    .led      (led),
    .num_data (num_data)
  );

  assign inst_sram_rdata = inst_rdata_q;
  assign data_sram_rdata = data_rdata_q;

  // The instruction port is read-only and byte offsets within a word are ignored.
  logic unused_ok;
  assign unused_ok = ^{inst_sram_we, inst_sram_wdata, inst_sram_addr[31:RAM_AW+2],
                       inst_sram_addr[1:0], data_sram_addr[1:0]};

endmodule
